// File: rtl/operand_loader.sv
// Loads two operands from a shared bus, strobes an external equality comparator and holds its
// registered answer until consumed. Define OPLOAD_TIMEOUT_EN to abort a stalled operand-B load.
module operand_loader #(
  parameter int unsigned inputsize      = 8,
  parameter int unsigned timeout_cycles = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [inputsize-1:0] data_in,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic [inputsize-1:0] A,
  output logic [inputsize-1:0] B,
  output logic                 enable,
  input  logic                 ab_in,
  output logic                 result,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic                 error
);

  typedef enum logic [2:0] {LOAD_A, LOAD_B, COMPARE, WAIT, DONE} state_e;

  if (timeout_cycles == 0) begin : g_bad_timeout
    $error("operand_loader: timeout_cycles must be nonzero");
  end

  state_e               r_state;
  logic [inputsize-1:0] r_a;
  logic [inputsize-1:0] r_b;
  logic                 r_enable;
  logic                 r_result;
  logic                 r_result_valid;
  logic                 r_data_ready;
  logic                 w_accept;
  logic                 w_timeout;

  assign w_accept = r_data_ready & data_valid;

`ifdef OPLOAD_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(timeout_cycles + 1);

  logic [CntW-1:0] r_cnt;
  logic            r_error;

  // Fires on the edge that ends the timeout_cycles-th consecutive idle LOAD_B cycle.
  assign w_timeout = (r_state == LOAD_B) && !data_valid &&
                     (r_cnt == CntW'(timeout_cycles - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_error <= 1'b0;
    end else begin
      r_error <= w_timeout;
      if ((r_state == LOAD_B) && !w_accept && !w_timeout) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign error = r_error;
`else
  assign w_timeout = 1'b0;
  assign error     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= LOAD_A;
      r_a            <= '0;
      r_b            <= '0;
      r_enable       <= 1'b0;
      r_result       <= 1'b0;
      r_result_valid <= 1'b0;
      r_data_ready   <= 1'b1;
    end else begin
      r_enable <= 1'b0;
      unique case (r_state)
        LOAD_A: begin
          if (w_accept) begin
            r_a     <= data_in;
            r_state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (w_accept) begin
            r_b          <= data_in;
            r_state      <= COMPARE;
            r_enable     <= 1'b1;
            r_data_ready <= 1'b0;
          end else if (w_timeout) begin
            r_state <= LOAD_A;
          end
        end
        COMPARE: begin
          r_state <= WAIT;
        end
        WAIT: begin
          // Comparator registered its answer at the COMPARE edge; it is valid only now.
          r_result       <= ab_in;
          r_result_valid <= 1'b1;
          r_state        <= DONE;
        end
        DONE: begin
          if (result_ready) begin
            r_result_valid <= 1'b0;
            r_data_ready   <= 1'b1;
            r_state        <= LOAD_A;
          end
        end
        default: begin
          r_state        <= LOAD_A;
          r_result_valid <= 1'b0;
          r_data_ready   <= 1'b1;
        end
      endcase
    end
  end

  assign data_ready   = r_data_ready;
  assign A            = r_a;
  assign B            = r_b;
  assign enable       = r_enable;
  assign result       = r_result;
  assign result_valid = r_result_valid;

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader; expected compare results go through a scoreboard queue.
// Covers the OPLOAD_TIMEOUT_EN build when that macro is defined, the plain build otherwise.
module tb_operand_loader;
  localparam int unsigned W  = 8;
  localparam int unsigned TO = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] data_in;
  logic         data_valid;
  logic         data_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         enable;
  logic         ab_in;
  logic         result;
  logic         result_valid;
  logic         result_ready;
  logic         error;

  int n_pass  = 0;
  int n_total = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  operand_loader #(
    .inputsize     (W),
    .timeout_cycles(TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .A           (A),
    .B           (B),
    .enable      (enable),
    .ab_in       (ab_in),
    .result      (result),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .error       (error)
  );

  // Comparator model: registers A==B on the enable edge, drives x otherwise.
  always @(posedge clk) ab_in <= enable ? (A == B) : 1'bx;

  task automatic load_pair(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk); data_in = a; data_valid = 1'b1;
    @(negedge clk); data_in = b;
  endtask

  task automatic collect(input string name);
    bit seen = 1'b0;
    bit exp;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (result_valid === 1'b1) seen = 1'b1;
    end
    n_total++;
    if (!seen) begin
      $display("FAIL %s_wait: result_valid got 0 want 1 within 8 cycles", name);
    end else if (exp_q.size() == 0) begin
      $display("FAIL %s_sb: got unexpected result %b want none", name, result);
    end else begin
      exp = exp_q.pop_front();
      if (result !== exp) $display("FAIL %s_result: got %b want %b", name, result, exp);
      else n_pass++;
    end
    result_ready = 1'b1;
    @(negedge clk); result_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; data_valid = 1'b0; data_in = '0; result_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    n_total++; if (data_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", data_ready);
    else n_pass++;
    n_total++; if (A !== '0 || B !== '0) $display("FAIL rst_ab: got %h/%h want 00/00", A, B);
    else n_pass++;
    n_total++;
    if ({enable, result, result_valid, error} !== 4'b0)
      $display("FAIL rst_flags: got %b want 0000", {enable, result, result_valid, error});
    else n_pass++;
  endtask

  task automatic test_equal();
    bit exp;
    @(negedge clk); data_in = 8'h5A; data_valid = 1'b1;
    @(negedge clk);
    n_total++; if (A !== 8'h5A) $display("FAIL eq_a: got %h want 5a", A); else n_pass++;
    data_in = 8'h5A; exp_q.push_back(1'b1);
    @(negedge clk); data_valid = 1'b0;
    n_total++; if (enable !== 1'b1) $display("FAIL eq_enable: got %b want 1", enable);
    else n_pass++;
    n_total++; if (data_ready !== 1'b0) $display("FAIL eq_ready: got %b want 0", data_ready);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (enable !== 1'b0 || result_valid !== 1'b0)
      $display("FAIL eq_wait: got en=%b rv=%b want 0/0", enable, result_valid);
    else n_pass++;
    @(negedge clk);
    n_total++; if (result_valid !== 1'b1) $display("FAIL eq_latency: got %b want 1", result_valid);
    else n_pass++;
    exp = exp_q.pop_front();
    n_total++; if (result !== exp) $display("FAIL eq_result: got %b want %b", result, exp);
    else n_pass++;
    result_ready = 1'b1;
    @(negedge clk); result_ready = 1'b0;
    n_total++;
    if (result_valid !== 1'b0 || data_ready !== 1'b1)
      $display("FAIL eq_release: got rv=%b rdy=%b want 0/1", result_valid, data_ready);
    else n_pass++;
  endtask

  task automatic test_not_equal_hold();
    bit exp;
    bit seen = 1'b0;
    load_pair(8'h12, 8'h13); exp_q.push_back(1'b0);
    @(negedge clk); data_valid = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (result_valid === 1'b1) seen = 1'b1;
    end
    n_total++; if (!seen) $display("FAIL ne_wait: result_valid got 0 want 1"); else n_pass++;
    exp = exp_q.pop_front();
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (result_valid !== 1'b1 || result !== exp)
        $display("FAIL ne_hold%0d: got rv=%b r=%b want 1/%b", i, result_valid, result, exp);
      else n_pass++;
      @(negedge clk);
    end
    result_ready = 1'b1;
    @(negedge clk); result_ready = 1'b0;
    n_total++; if (result_valid !== 1'b0) $display("FAIL ne_drop: got %b want 0", result_valid);
    else n_pass++;
  endtask

  task automatic test_ignore_data();
    bit exp;
    load_pair(8'h33, 8'h44); exp_q.push_back(1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++;
      if (data_ready !== 1'b0 || A !== 8'h33 || B !== 8'h44)
        $display("FAIL ign_c%0d: got rdy=%b A=%h B=%h want 0/33/44", i, data_ready, A, B);
      else n_pass++;
      data_in = W'($urandom);
    end
    n_total++;
    if (result_valid !== 1'b1) $display("FAIL ign_rv: got %b want 1", result_valid);
    else begin
      exp = exp_q.pop_front();
      if (result !== exp) $display("FAIL ign_result: got %b want %b", result, exp);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    // Entered in DONE with data_valid still high.
    data_in = 8'hEE; result_ready = 1'b1;
    @(negedge clk); result_ready = 1'b0;
    n_total++;
    if (A !== 8'h33 || data_ready !== 1'b1 || result_valid !== 1'b0)
      $display("FAIL b2b_noaccept: got A=%h rdy=%b rv=%b want 33/1/0", A, data_ready,
               result_valid);
    else n_pass++;
    data_in = 8'h77;
    @(negedge clk);
    n_total++; if (A !== 8'h77) $display("FAIL b2b_a: got %h want 77", A); else n_pass++;
    data_in = 8'h77; exp_q.push_back(1'b1);
    @(negedge clk); data_valid = 1'b0;
    collect("b2b");
  endtask

  task automatic test_reset_mid_compare();
    bit rv_seen = 1'b0;
    load_pair(8'hAA, 8'hAA);
    @(negedge clk); data_valid = 1'b0;
    n_total++; if (enable !== 1'b1) $display("FAIL rmc_enable: got %b want 1", enable);
    else n_pass++;
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    n_total++;
    if (enable !== 1'b0 || A !== '0 || B !== '0 || data_ready !== 1'b1)
      $display("FAIL rmc_state: got en=%b A=%h B=%h rdy=%b want 0/00/00/1", enable, A, B,
               data_ready);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (result_valid !== 1'b0) rv_seen = 1'b1;
    end
    n_total++; if (rv_seen) $display("FAIL rmc_rv: got 1 want 0"); else n_pass++;
  endtask

  task automatic test_timeout();
    @(negedge clk); data_in = 8'h21; data_valid = 1'b1;
    @(negedge clk); data_valid = 1'b0;
    n_total++; if (A !== 8'h21) $display("FAIL to_a: got %h want 21", A); else n_pass++;
`ifdef OPLOAD_TIMEOUT_EN
    for (int i = 1; i <= int'(TO); i++) begin
      @(negedge clk);
      n_total++;
      if (error !== (i == int'(TO)) || data_ready !== 1'b1)
        $display("FAIL to_idle%0d: got err=%b rdy=%b want %b/1", i, error, data_ready,
                 (i == int'(TO)));
      else n_pass++;
    end
    data_in = 8'h99; data_valid = 1'b1;
    @(negedge clk);
    n_total++;
    if (A !== 8'h99 || error !== 1'b0)
      $display("FAIL to_reload: got A=%h err=%b want 99/0", A, error);
    else n_pass++;
    data_in = 8'h99; exp_q.push_back(1'b1);
    @(negedge clk); data_valid = 1'b0;
    collect("to");
`else
    begin
      bit err_seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (error !== 1'b0) err_seen = 1'b1;
      end
      n_total++; if (err_seen) $display("FAIL nto_error: got 1 want 0"); else n_pass++;
    end
    n_total++; if (data_ready !== 1'b1) $display("FAIL nto_ready: got %b want 1", data_ready);
    else n_pass++;
    data_in = 8'h99; data_valid = 1'b1; exp_q.push_back(1'b0);
    @(negedge clk); data_valid = 1'b0;
    n_total++;
    if (A !== 8'h21 || B !== 8'h99)
      $display("FAIL nto_b: got A=%h B=%h want 21/99", A, B);
    else n_pass++;
    collect("nto");
`endif
  endtask

  initial begin
    reset = 1'b1; data_valid = 1'b0; data_in = '0; result_ready = 1'b0;
    test_reset();
    test_equal();
    test_not_equal_hold();
    test_ignore_data();
    test_back_to_back();
    test_reset_mid_compare();
    test_timeout();
    n_total++;
    if (exp_q.size() != 0) $display("FAIL sb_empty: got %0d pending want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
